// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: machine word, RAM handshake state, and the
// definitions used by the memory arbiter that sits between caches and RAM.
package cpu_types_pkg;

    localparam int WORD_W = 32;
    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } arb_state_t;

    localparam int STREAK_W            = 3;
    localparam int MAX_DSTREAK_DEFAULT = 4;

    function automatic logic [STREAK_W-1:0] sat_inc(
        input logic [STREAK_W-1:0] v,
        input logic [STREAK_W-1:0] lim
    );
        return (v < lim) ? v + STREAK_W'(1) : lim;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester RAM arbiter: data side normally wins, but after MAX_DSTREAK
// back-to-back data grants a waiting instruction fetch is served.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int MAX_DSTREAK = MAX_DSTREAK_DEFAULT  // must fit in STREAK_W bits
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        ramerr
);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DSTREAK);

    arb_state_t          state_q, state_d;
    logic [STREAK_W-1:0] streak_q, streak_d;

    ramstate_t ram_st;
    logic      d_req;
    logic      i_active, d_active;
    logic      i_done, d_done;

    assign ram_st = ramstate_t'(ramstate);
    assign d_req  = dREN | dWEN;

    // A grant only drives the RAM while its requester still holds the request,
    // so a dropped request aborts in the same cycle.
    assign i_active = (state_q == IGRANT) & iREN;
    assign d_active = (state_q == DGRANT) & d_req;
    assign i_done   = i_active & (ram_st == ACCESS);
    assign d_done   = d_active & (ram_st == ACCESS);

    assign iwait  = iREN  & ~i_done;
    assign dwait  = d_req & ~d_done;
    assign iload  = i_done ? ramload : '0;
    assign dload  = d_done ? ramload : '0;
    assign ramerr = (i_active | d_active) & (ram_st == ERROR);

    // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        if (i_active) begin
            ramREN  = 1'b1;
            ramaddr = iaddr;
        end else if (d_active) begin
            ramWEN   = dWEN;
            ramREN   = dREN & ~dWEN;
            ramaddr  = daddr;
            ramstore = dstore;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (d_req && ((streak_q < STREAK_MAX) || !iREN)) begin
                    state_d = DGRANT;
                end else if (iREN) begin
                    state_d = IGRANT;
                end
            end
            IGRANT: begin
                if (!iREN || ram_st == ACCESS || ram_st == ERROR) begin
                    state_d = IDLE;
                end
            end
            DGRANT: begin
                if (!d_req || ram_st == ACCESS || ram_st == ERROR) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The streak only matters while a fetch is waiting, so it is cleared
    // whenever the instruction side is quiet or gets served.
    always_comb begin
        streak_d = streak_q;
        if (!iREN || i_done) begin
            streak_d = '0;
        end else if (d_done) begin
            streak_d = sat_inc(streak_q, STREAK_MAX);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized
// run checked against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int MAXS = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        iREN, dREN, dWEN;
    word_t       iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramREN, ramWEN, ramerr;
    word_t       iload, dload, ramaddr, ramstore;
    logic [132:0] dut_bus;

    int total = 0;
    int bad   = 0;

    // Model: who currently owns the RAM (0 nobody, 1 fetch, 2 data) and how
    // many data completions have happened while the fetch was waiting.
    int m_side   = 0;
    int m_streak = 0;

    always #5 CLK = ~CLK;

    mem_arbiter #(.MAX_DSTREAK(MAXS)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .ramerr(ramerr)
    );

    assign dut_bus = {iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, ramerr};

    function automatic logic [132:0] exp_bus();
        int    side  = RST ? 0 : m_side;
        bit    i_own = (side == 1) && iREN;
        bit    d_own = (side == 2) && (dREN || dWEN);
        logic  e_iw, e_dw, e_rr, e_rw, e_er;
        word_t e_il, e_dl, e_ad, e_st;
        e_rr = 0; e_rw = 0; e_er = 0;
        e_il = 0; e_dl = 0; e_ad = 0; e_st = 0;
        if (i_own) begin
            e_rr = 1; e_ad = iaddr;
            if (ramstate == ACCESS) e_il = ramload;
            if (ramstate == ERROR)  e_er = 1;
        end
        if (d_own) begin
            if (dWEN) e_rw = 1; else e_rr = 1;
            e_ad = daddr; e_st = dstore;
            if (ramstate == ACCESS) e_dl = ramload;
            if (ramstate == ERROR)  e_er = 1;
        end
        e_iw = iREN && !(i_own && ramstate == ACCESS);
        e_dw = (dREN || dWEN) && !(d_own && ramstate == ACCESS);
        return {e_iw, e_il, e_dw, e_dl, e_rr, e_rw, e_ad, e_st, e_er};
    endfunction

    // Advance one clock and apply the arbitration rules to the model.
    task automatic tick();
        bit dreq;
        int nside, nstreak;
        @(posedge CLK);
        dreq    = dREN || dWEN;
        nside   = m_side;
        nstreak = m_streak;
        if (RST) begin
            nside = 0; nstreak = 0;
        end else begin
            case (m_side)
                0: if (dreq && (m_streak < MAXS || !iREN)) nside = 2;
                   else if (iREN) nside = 1;
                1: if (!iREN || ramstate == ACCESS || ramstate == ERROR) begin
                       nside = 0;
                       if (iREN && ramstate == ACCESS) nstreak = 0;
                   end
                default: if (!dreq || ramstate == ACCESS || ramstate == ERROR) begin
                       nside = 0;
                       if (dreq && ramstate == ACCESS && iREN)
                           nstreak = (m_streak + 1 > MAXS) ? MAXS : m_streak + 1;
                   end
            endcase
            if (!iREN) nstreak = 0;
        end
        m_side   = nside;
        m_streak = nstreak;
        #1;
    endtask

    task automatic drive_idle();
        iREN = 0; dREN = 0; dWEN = 0;
        iaddr = 0; daddr = 0; dstore = 0; ramload = 0;
        ramstate = FREE;
    endtask

    task automatic do_reset();
        drive_idle();
        RST = 1;
        m_side = 0; m_streak = 0;
        tick(); tick();
        RST = 0;
    endtask

    task automatic test_reset();
        drive_idle();
        RST = 1;
        tick();
        iREN = 1; ramstate = ACCESS; ramload = 32'hDEAD_BEEF;
        iaddr = 32'h1234; daddr = 32'h5678; dstore = 32'h9ABC;
        #2;
        total++;
        if ({ramREN, ramWEN, ramaddr, ramstore, iload, dload, ramerr} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%h required=0",
                     {ramREN, ramWEN, ramaddr, ramstore, iload, dload, ramerr});
        end
        total++;
        if ({iwait, dwait} !== 2'b10) begin
            bad++; $display("FAIL reset_waits got=%b required=10", {iwait, dwait});
        end
        dREN = 1; #1;
        total++;
        if ({iwait, dwait} !== 2'b11) begin
            bad++; $display("FAIL reset_waits_dreq got=%b required=11", {iwait, dwait});
        end
        do_reset();
    endtask

    task automatic test_ifetch();
        logic [65:0] got, exp;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            iREN     = (c < 5);
            iaddr    = 32'h40;
            ramstate = (c == 0 || c == 5) ? FREE : (c == 4) ? ACCESS : BUSY;
            ramload  = 32'hCAFE_F00D + c;
            #2;
            got = {ramREN, iwait, iload, ramaddr};
            exp = {(c >= 1 && c <= 4), (c < 4), (c == 4) ? ramload : 32'h0,
                   (c >= 1 && c <= 4) ? 32'h40 : 32'h0};
            total++;
            if (got !== exp) begin
                bad++; $display("FAIL ifetch c%0d got=%h required=%h", c, got, exp);
            end
            tick();
        end
    endtask

    task automatic test_simultaneous();
        logic [65:0] got, exp;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            iREN = (c < 4); dWEN = (c < 2);
            iaddr = 32'h44; daddr = 32'h80; dstore = 32'h1234_5678;
            ramstate = ACCESS; ramload = 32'h0BAD_0000 + c;
            #2;
            got = {ramREN, ramWEN, ramaddr, ramstore};
            case (c)
                1:       exp = {1'b0, 1'b1, 32'h80, 32'h1234_5678};
                3:       exp = {1'b1, 1'b0, 32'h44, 32'h0};
                default: exp = '0;
            endcase
            total++;
            if (got !== exp) begin
                bad++; $display("FAIL simultaneous c%0d got=%h required=%h", c, got, exp);
            end
            tick();
        end
        drive_idle();
    endtask

    task automatic test_streak();
        string seq = "";
        bit    prev_done = 0;
        bit    now_done;
        int    overlaps = 0;
        do_reset();
        iREN = 1; dREN = 1; ramstate = ACCESS;
        for (int c = 0; c < 20; c++) begin
            iaddr = 32'h100 + c; daddr = 32'h200 + c; ramload = $urandom;
            #2;
            total++;
            if (dut_bus !== exp_bus()) begin
                bad++; $display("FAIL streak_bus c%0d got=%h required=%h", c, dut_bus, exp_bus());
            end
            now_done = 0;
            if (!dwait) begin seq = {seq, "D"}; now_done = 1; end
            if (!iwait) begin seq = {seq, "I"}; now_done = 1; end
            if (now_done && prev_done) overlaps++;
            prev_done = now_done;
            tick();
        end
        total++;
        if (seq != "DDDDIDDDDI") begin
            bad++; $display("FAIL streak_pattern got=%s required=DDDDIDDDDI", seq);
        end
        total++;
        if (overlaps != 0) begin
            bad++; $display("FAIL no_back_to_back got=%0d required=0", overlaps);
        end
        drive_idle();
    endtask

    task automatic test_rw_both();
        do_reset();
        dREN = 1; dWEN = 1; daddr = 32'h300; dstore = 32'h55AA_55AA; ramstate = BUSY;
        tick();
        #2;
        total++;
        if ({ramWEN, ramREN, ramstore} !== {2'b10, 32'h55AA_55AA}) begin
            bad++; $display("FAIL rw_both got=%h required=%h",
                            {ramWEN, ramREN, ramstore}, {2'b10, 32'h55AA_55AA});
        end
        drive_idle();
        tick();
    endtask

    task automatic test_error();
        logic [34:0] got, exp;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            dREN = (c < 4); daddr = 32'h400;
            ramstate = (c == 1) ? ERROR : (c == 3) ? ACCESS : FREE;
            ramload  = 32'h7777_0000 + c;
            #2;
            got = {ramerr, dwait, ramREN, dload};
            case (c)
                1:       exp = {3'b111, 32'h0};
                3:       exp = {3'b001, ramload};
                4:       exp = '0;
                default: exp = {3'b010, 32'h0};
            endcase
            total++;
            if (got !== exp) begin
                bad++; $display("FAIL error c%0d got=%h required=%h", c, got, exp);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        iREN = 1; iaddr = 32'h100; ramstate = FREE;
        tick();
        ramstate = BUSY;
        #2;
        total++;
        if (ramREN !== 1'b1) begin
            bad++; $display("FAIL rst_mid_pre ramREN got=%b required=1", ramREN);
        end
        RST = 1; m_side = 0; m_streak = 0;
        #1;
        total++;
        if ({ramREN, ramaddr, ramerr, iwait} !== {1'b0, 32'h0, 1'b0, 1'b1}) begin
            bad++; $display("FAIL rst_mid_drop got=%h required=%h",
                            {ramREN, ramaddr, ramerr, iwait}, {1'b0, 32'h0, 1'b0, 1'b1});
        end
        tick();
        RST = 0;
        #2;
        total++;
        if ({ramREN, iwait} !== 2'b01) begin
            bad++; $display("FAIL rst_mid_idle got=%b required=01", {ramREN, iwait});
        end
        tick();
        ramstate = ACCESS; ramload = 32'hFEED_0001;
        #2;
        total++;
        if ({ramREN, iwait, iload} !== {2'b10, 32'hFEED_0001}) begin
            bad++; $display("FAIL rst_mid_restart got=%h required=%h",
                            {ramREN, iwait, iload}, {2'b10, 32'hFEED_0001});
        end
        tick();
        drive_idle();
        tick();
    endtask

    task automatic test_random();
        int r;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(7) == 0) iREN = ~iREN;
            if ($urandom_range(7) == 0) dREN = ~dREN;
            if ($urandom_range(9) == 0) dWEN = ~dWEN;
            iaddr = $urandom; daddr = $urandom; dstore = $urandom; ramload = $urandom;
            r = $urandom_range(99);
            ramstate = (r < 40) ? ACCESS : (r < 70) ? BUSY : (r < 90) ? FREE : ERROR;
            RST = ($urandom_range(149) == 0);
            #2;
            total++;
            if (dut_bus !== exp_bus()) begin
                bad++; $display("FAIL random c%0d got=%h required=%h", c, dut_bus, exp_bus());
            end
            tick();
        end
        RST = 0;
        drive_idle();
    endtask

    initial begin
        test_reset();
        test_ifetch();
        test_simultaneous();
        test_streak();
        test_rw_both();
        test_error();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
